gc_dec8: RTL and testbench

- Receive-side companion to the 8-bit Gray-code up/down counter.
- Samples a Gray-coded count arriving from another clock domain or a pin, synchronises it into clk, decodes it to binary and classifies each accepted change as one step up, one step down, or an illegal jump.
- Feeds position/rate logic with a clean binary count, step pulses and an error indication.

---
 rtl/gc_dec8.sv | 175 +++++++++++++++++
 tb/tb_gc_dec8.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_dec8.sv
// ============================================================================
// gc_dec8 -- Gray-code receive decoder
//
// Receive-side companion to the 8-bit Gray-code up/down counter. The Gray
// count arrives from another clock domain or a pin. It is synchronised into
// clk, decoded to binary and each accepted change is classified as one step
// up, one step down, or an illegal jump.
//
// Parameters:
//   WIDTH        width of the Gray input and binary output (min 2)
//   SYNC_STAGES  synchroniser flop depth (min 2)
//
// Ports:
//   clk      in   system clock
//   rstn     in   asynchronous active-low reset
//   gc_in    in   [WIDTH] asynchronous Gray-coded count
//   clr      in   synchronous clear of err and err_cnt
//   bin      out  [WIDTH] decoded binary count, registered
//   bin_vld  out  bin holds a decoded sample
//   step_up  out  one-cycle pulse, accepted value = previous + 1
//   step_dn  out  one-cycle pulse, accepted value = previous - 1
//   err_pls  out  one-cycle pulse, illegal jump detected
//   err      out  sticky error flag
//   err_cnt  out  [8] saturating illegal-jump count
//
// Optional feature (macro GC_DEC8_FILTER_EN):
//   Adds a stability register g_f after the synchroniser. A sample is only
//   accepted when it has been identical for two consecutive cycles. This
//   adds one cycle of latency and one cycle of priming.
// ============================================================================
module gc_dec8 #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] gc_in,
   input  logic             clr,
   output logic [WIDTH-1:0] bin,
   output logic             bin_vld,
   output logic             step_up,
   output logic             step_dn,
   output logic             err_pls,
   output logic             err,
   output logic [7:0]       err_cnt
);

`ifdef GC_DEC8_FILTER_EN
   localparam int PRIME_CYC = SYNC_STAGES + 1;
`else
   localparam int PRIME_CYC = SYNC_STAGES;
`endif
   localparam int CNT_W = $clog2(PRIME_CYC + 1);

   typedef enum logic {
      PRIME,
      TRACK
   } state_t;

   state_t                              state;
   logic [CNT_W-1:0]                    prime_cnt;
   logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync;
   logic [WIDTH-1:0]                    g_s;
   logic [WIDTH-1:0]                    d;
   logic [WIDTH-1:0]                    delta;
   logic                                accept;

   // Plain flop chain per bit; nothing may sit between stages so that each
   // bit gets the full metastability settling time.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], gc_in};
      end
   end

   assign g_s = sync[SYNC_STAGES-1];

`ifdef GC_DEC8_FILTER_EN
   logic [WIDTH-1:0] g_f;

   // One-cycle delayed copy of the synchronised value; a sample that differs
   // from its predecessor may be a mid-transition capture and is ignored.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         g_f <= '0;
      end else begin
         g_f <= g_s;
      end
   end

   assign accept = (g_s == g_f);
`else
   assign accept = 1'b1;
`endif

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above
   // its position. Written as a reduction of a shifted copy so no bit of d
   // feeds back into the same block.
   always_comb begin
      d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         d[i] = ^(g_s >> i);
      end
   end

   // Modulo difference between the new decoded value and the held one;
   // +1 and all-ones (-1) are the only legal non-zero steps.
   assign delta = d - bin;

   // Control FSM with all outputs registered. PRIME lets the synchroniser
   // flush after reset before the first value is trusted. TRACK classifies
   // every accepted sample and always reloads bin, so a jump resynchronises.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= PRIME;
         prime_cnt <= '0;
         bin       <= '0;
         bin_vld   <= 1'b0;
         step_up   <= 1'b0;
         step_dn   <= 1'b0;
         err_pls   <= 1'b0;
         err       <= 1'b0;
         err_cnt   <= '0;
      end else begin
         step_up <= 1'b0;
         step_dn <= 1'b0;
         err_pls <= 1'b0;

         // A clear in the same cycle as an illegal jump is overridden by the
         // error assignments further down, so the error is never lost.
         if (clr) begin
            err     <= 1'b0;
            err_cnt <= '0;
         end

         case (state)
            PRIME: begin
               if (prime_cnt == CNT_W'(PRIME_CYC)) begin
                  bin     <= d;
                  bin_vld <= 1'b1;
                  state   <= TRACK;
               end else begin
                  prime_cnt <= prime_cnt + CNT_W'(1);
               end
            end

            TRACK: begin
               if (accept) begin
                  bin <= d;
                  if (delta == WIDTH'(1)) begin
                     step_up <= 1'b1;
                  end else if (delta == '1) begin
                     step_dn <= 1'b1;
                  end else if (delta != '0) begin
                     err_pls <= 1'b1;
                     err     <= 1'b1;
                     if (clr) begin
                        err_cnt <= 8'd1;
                     end else if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                     end
                  end
               end
            end

            default: begin
               state <= PRIME;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gc_dec8.sv
// ============================================================================
// tb_gc_dec8 -- self-checking bench for gc_dec8 (WIDTH 8, SYNC_STAGES 2)
//
// Directed steps in one initial block. Every Gray value driven pushes its
// expected result (binary value, pulse kind, sticky error state) onto a
// scoreboard queue; the entry is popped and compared on the clock edge where
// the decoder must present it.
// ============================================================================
module tb_gc_dec8;

`ifdef GC_DEC8_FILTER_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   typedef struct {
      logic [7:0] bin;
      logic       up;
      logic       dn;
      logic       ep;
      logic       err;
      logic [7:0] cnt;
   } exp_t;

   logic       clk;
   logic       rstn;
   logic [7:0] gc_in;
   logic       clr;
   logic [7:0] bin;
   logic       bin_vld;
   logic       step_up;
   logic       step_dn;
   logic       err_pls;
   logic       err;
   logic [7:0] err_cnt;

   int         checks;
   int         errors;
   exp_t       sb[$];

   // Model state, updated when stimulus is driven
   logic [7:0] m_bin;
   logic       m_err;
   logic [7:0] m_cnt;

   gc_dec8 #(
      .WIDTH       (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .gc_in   (gc_in),
      .clr     (clr),
      .bin     (bin),
      .bin_vld (bin_vld),
      .step_up (step_up),
      .step_dn (step_dn),
      .err_pls (err_pls),
      .err     (err),
      .err_cnt (err_cnt)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkNoPulse(input string tag);
      checkOutput({tag, " step_up"}, 32'(step_up), 32'd0);
      checkOutput({tag, " step_dn"}, 32'(step_dn), 32'd0);
      checkOutput({tag, " err_pls"}, 32'(err_pls), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " bin"}, 32'(bin), 32'd0);
      checkOutput({tag, " bin_vld"}, 32'(bin_vld), 32'd0);
      checkNoPulse(tag);
      checkOutput({tag, " err"}, 32'(err), 32'd0);
      checkOutput({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
   endtask

   // Drive one Gray value whose binary meaning is exp_bin, push the expected
   // result, then compare it LAT edges later. Optionally asserts clr so that
   // it coincides with the edge on which the new value is evaluated.
   task automatic applyStimulus(input string tag, input logic [7:0] g, input logic [7:0] exp_bin,
                                input bit clr_at_eval);
      exp_t       e;
      logic [7:0] dlt;
      @(negedge clk);
      gc_in = g;
      dlt   = exp_bin - m_bin;
      e.bin = exp_bin;
      e.up  = (dlt == 8'd1);
      e.dn  = (dlt == 8'hFF);
      e.ep  = (dlt != 8'd0) && (dlt != 8'd1) && (dlt != 8'hFF);
      if (clr_at_eval) begin
         m_err = 1'b0;
         m_cnt = 8'd0;
      end
      if (e.ep) begin
         m_err = 1'b1;
         m_cnt = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
      end
      m_bin = exp_bin;
      e.err = m_err;
      e.cnt = m_cnt;
      sb.push_back(e);

      repeat (LAT - 1) @(posedge clk);
      #1;
      checkNoPulse({tag, " early"});
      if (clr_at_eval) begin
         @(negedge clk);
         clr = 1'b1;
      end
      @(posedge clk);
      #1;
      clr = 1'b0;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL %s scoreboard empty observed 0 expected 1", tag);
      end else begin
         e = sb.pop_front();
         checkOutput({tag, " bin"}, 32'(bin), 32'(e.bin));
         checkOutput({tag, " step_up"}, 32'(step_up), 32'(e.up));
         checkOutput({tag, " step_dn"}, 32'(step_dn), 32'(e.dn));
         checkOutput({tag, " err_pls"}, 32'(err_pls), 32'(e.ep));
         checkOutput({tag, " err"}, 32'(err), 32'(e.err));
         checkOutput({tag, " err_cnt"}, 32'(err_cnt), 32'(e.cnt));
      end
      @(posedge clk);
      #1;
      checkNoPulse({tag, " after"});
   endtask

   task automatic clearErrors(input string tag);
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr   = 1'b0;
      m_err = 1'b0;
      m_cnt = 8'd0;
      checkOutput({tag, " err"}, 32'(err), 32'd0);
      checkOutput({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
   endtask

   // Release reset and confirm bin_vld rises exactly on edge LAT with the
   // held input value and no pulses.
   task automatic primeCheck(input string tag, input logic [7:0] exp_bin);
      @(negedge clk);
      rstn = 1'b1;
      repeat (LAT - 1) @(posedge clk);
      #1;
      checkOutput({tag, " vld early"}, 32'(bin_vld), 32'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, " vld"}, 32'(bin_vld), 32'd1);
      checkOutput({tag, " bin"}, 32'(bin), 32'(exp_bin));
      checkNoPulse(tag);
      repeat (2) @(posedge clk);
      #1;
      checkNoPulse({tag, " settle"});
      checkOutput({tag, " err"}, 32'(err), 32'd0);
      m_bin = exp_bin;
      m_err = 1'b0;
      m_cnt = 8'd0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstn   = 1'b0;
      gc_in  = 8'h00;
      clr    = 1'b0;
      m_bin  = 8'h00;
      m_err  = 1'b0;
      m_cnt  = 8'd0;

      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      primeCheck("prime", 8'h00);

      // Up counting: Gray 01, 03, 02 = binary 1, 2, 3
      applyStimulus("up1", 8'h01, 8'h01, 1'b0);
      applyStimulus("up2", 8'h03, 8'h02, 1'b0);
      applyStimulus("up3", 8'h02, 8'h03, 1'b0);

      // Down counting back to zero, then across the wrap in both directions
      applyStimulus("dn2", 8'h03, 8'h02, 1'b0);
      applyStimulus("dn1", 8'h01, 8'h01, 1'b0);
      applyStimulus("dn0", 8'h00, 8'h00, 1'b0);
      applyStimulus("wrap_dn", 8'h80, 8'hFF, 1'b0);
      applyStimulus("wrap_up", 8'h00, 8'h00, 1'b0);

      // Illegal jump 1 -> 4, sticky flag, then clear
      applyStimulus("up_to1", 8'h01, 8'h01, 1'b0);
      applyStimulus("jump", 8'h06, 8'h04, 1'b0);
      checkOutput("jump held err", 32'(err), 32'd1);
      clearErrors("clr");

      // Clear coincident with an illegal jump 4 -> 0: error wins
      applyStimulus("clr_vs_err", 8'h00, 8'h00, 1'b1);

      // 256 back-to-back illegal jumps between binary 0 and 4
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         gc_in = (i % 2 == 0) ? 8'h06 : 8'h00;
         m_cnt = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
      end
      repeat (LAT + 1) @(posedge clk);
      #1;
      checkOutput("sat err_cnt", 32'(err_cnt), 32'(m_cnt));
      checkOutput("sat err_cnt 255", 32'(err_cnt), 32'hFF);
      checkOutput("sat bin", 32'(bin), 32'h00);
      checkNoPulse("sat settled");

      // One more jump to 0x5A (Gray 0x77) while saturated
      applyStimulus("to5a", 8'h77, 8'h5A, 1'b0);

      // Asynchronous reset mid-run: outputs clear before any clock edge
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      checkAllZero("mid_reset");
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("mid_reset held");
      primeCheck("reprime", 8'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
